// File: rtl/holy_irq_claim_sequencer_if.sv
// AXI-Lite bus bundle used between the claim sequencer (master) and the PLIC (slave).
interface axi_lite_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/holy_irq_claim_sequencer.sv
// Hardware PLIC claim/complete sequencer: claims via AXI-Lite read, hands the ID to the core,
// and writes it back to the complete register once the core reports done.
module holy_irq_claim_sequencer #(
  parameter logic [31:0] PLIC_BASE  = 32'h0,
  parameter int unsigned ID_W       = 4,
  parameter int unsigned HOLDOFF    = 2,
  parameter int unsigned SPUR_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  ext_irq_i,
  output logic                  irq_valid_o,
  input  logic                  irq_ready_i,
  output logic [ID_W-1:0]       irq_id_o,
  input  logic                  irq_done_i,
  output logic                  busy_o,
  output logic                  bus_err_o,
  output logic [SPUR_CNT_W-1:0] spur_cnt_o,
  axi_lite_if.master            m_axi_lite
);

  localparam int unsigned HOLD_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_AR, S_R, S_DELIVER, S_SERVICE, S_AW, S_W, S_B, S_HOLD
  } state_t;

  state_t              state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                arvalid_q;
  logic                rready_q;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                bready_q;

  assign m_axi_lite.araddr  = PLIC_BASE + 32'h4;
  assign m_axi_lite.awaddr  = PLIC_BASE + 32'h4;
  assign m_axi_lite.arprot  = '0;
  assign m_axi_lite.awprot  = '0;
  assign m_axi_lite.wstrb   = 4'hF;
  assign m_axi_lite.wdata   = 32'(irq_id_o);
  assign m_axi_lite.arvalid = arvalid_q;
  assign m_axi_lite.rready  = rready_q;
  assign m_axi_lite.awvalid = awvalid_q;
  assign m_axi_lite.wvalid  = wvalid_q;
  assign m_axi_lite.bready  = bready_q;

  // Only the low ID_W bits of the claim word carry the interrupt ID.
  logic unused_rdata;
  assign unused_rdata = &{1'b0, m_axi_lite.rdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      hold_cnt    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      irq_valid_o <= 1'b0;
      irq_id_o    <= '0;
      busy_o      <= 1'b0;
      bus_err_o   <= 1'b0;
      spur_cnt_o  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (en_i && ext_irq_i) begin
            state     <= S_AR;
            arvalid_q <= 1'b1;
            busy_o    <= 1'b1;
          end
        end
        S_AR: begin
          if (m_axi_lite.arready) begin
            state     <= S_R;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
        end
        S_R: begin
          if (m_axi_lite.rvalid) begin
            rready_q <= 1'b0;
            if (m_axi_lite.rresp != 2'b00) begin
              bus_err_o <= 1'b1;
              state     <= S_HOLD;
              hold_cnt  <= HOLD_W'(HOLDOFF);
              busy_o    <= 1'b0;
            end else if (m_axi_lite.rdata[ID_W-1:0] == '0) begin
              if (spur_cnt_o != '1) spur_cnt_o <= spur_cnt_o + SPUR_CNT_W'(1);
              state    <= S_HOLD;
              hold_cnt <= HOLD_W'(HOLDOFF);
              busy_o   <= 1'b0;
            end else begin
              irq_id_o    <= m_axi_lite.rdata[ID_W-1:0];
              irq_valid_o <= 1'b1;
              state       <= S_DELIVER;
            end
          end
        end
        S_DELIVER: begin
          if (irq_ready_i) begin
            irq_valid_o <= 1'b0;
            state       <= S_SERVICE;
          end
        end
        S_SERVICE: begin
          if (irq_done_i) begin
            awvalid_q <= 1'b1;
            state     <= S_AW;
          end
        end
        S_AW: begin
          if (m_axi_lite.awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            state     <= S_W;
          end
        end
        S_W: begin
          if (m_axi_lite.wready) begin
            wvalid_q <= 1'b0;
            bready_q <= 1'b1;
            state    <= S_B;
          end
        end
        S_B: begin
          if (m_axi_lite.bvalid) begin
            bready_q <= 1'b0;
            if (m_axi_lite.bresp != 2'b00) bus_err_o <= 1'b1;
            state    <= S_HOLD;
            hold_cnt <= HOLD_W'(HOLDOFF);
            busy_o   <= 1'b0;
          end
        end
        S_HOLD: begin
          // The last HOLD cycle makes the IDLE decision itself, so a still-pending
          // irq issues its claim exactly HOLDOFF+1 cycles after the previous handshake.
          if (hold_cnt == '0) begin
            if (en_i && ext_irq_i) begin
              state     <= S_AR;
              arvalid_q <= 1'b1;
              busy_o    <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_holy_irq_claim_sequencer.sv
// Directed + randomized bench for the claim sequencer with a behavioural PLIC/AXI slave model.
module tb_holy_irq_claim_sequencer;

  localparam logic [31:0] BASE    = 32'h0C00_0000;
  localparam int unsigned ID_W    = 4;
  localparam int unsigned HOLDOFF = 2;

  logic clk = 1'b0;
  logic rst, en_i, ext_irq, irq_ready, irq_done;
  logic irq_valid_o, busy_o, bus_err_o;
  logic [ID_W-1:0] irq_id_o;
  logic [7:0] spur_cnt_o;

  axi_lite_if bus ();

  holy_irq_claim_sequencer #(
    .PLIC_BASE(BASE), .ID_W(ID_W), .HOLDOFF(HOLDOFF), .SPUR_CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .ext_irq_i(ext_irq),
    .irq_valid_o(irq_valid_o), .irq_ready_i(irq_ready), .irq_id_o(irq_id_o),
    .irq_done_i(irq_done), .busy_o(busy_o), .bus_err_o(bus_err_o),
    .spur_cnt_o(spur_cnt_o), .m_axi_lite(bus)
  );

  always #5 clk = ~clk;

  // PLIC slave model: programmable ready delays, read data from claim_data, write response wr_resp.
  int unsigned ar_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  int unsigned ar_c, aw_c, w_c, b_c;
  logic b_pend;
  logic [31:0] claim_data = '0;
  logic [1:0] claim_resp = '0, wr_resp = '0;

  assign bus.arready = (ar_c >= ar_dly);
  assign bus.awready = (aw_c >= aw_dly);
  assign bus.wready  = (w_c >= w_dly);

  always @(posedge clk) begin
    if (rst) begin
      ar_c <= 0; aw_c <= 0; w_c <= 0; b_c <= 0; b_pend <= 1'b0;
      bus.rvalid <= 1'b0; bus.rdata <= '0; bus.rresp <= '0;
      bus.bvalid <= 1'b0; bus.bresp <= '0;
    end else begin
      if (bus.arvalid && bus.arready) ar_c <= 0; else if (bus.arvalid) ar_c <= ar_c + 1;
      if (bus.awvalid && bus.awready) aw_c <= 0; else if (bus.awvalid) aw_c <= aw_c + 1;
      if (bus.wvalid && bus.wready) w_c <= 0; else if (bus.wvalid) w_c <= w_c + 1;
      if (bus.arvalid && bus.arready) begin
        bus.rvalid <= 1'b1; bus.rdata <= claim_data; bus.rresp <= claim_resp;
      end else if (bus.rvalid && bus.rready) begin
        bus.rvalid <= 1'b0;
      end
      if (bus.wvalid && bus.wready) begin
        b_pend <= 1'b1; b_c <= 0;
      end else if (b_pend && !bus.bvalid) begin
        if (b_c >= b_dly) begin bus.bvalid <= 1'b1; bus.bresp <= wr_resp; end
        else b_c <= b_c + 1;
      end
      if (bus.bvalid && bus.bready) begin bus.bvalid <= 1'b0; b_pend <= 1'b0; end
    end
  end

  // Bus monitor: handshake counts, timestamps and protocol-violation flags.
  int unsigned cyc = 0, n_ar = 0, n_aw = 0, n_w = 0, n_b = 0;
  int unsigned b_cyc = 0, r_cyc = 0, ar_rise_cyc = 0;
  logic [31:0] last_wdata = '0, last_araddr = '0, last_awaddr = '0;
  logic ar_p = 0, arr_p = 0, aw_p = 0, awr_p = 0, wv_p = 0, wr_p = 0, rst_p = 1;
  logic ovl_err = 0, stab_err = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.awvalid && bus.wvalid) ovl_err <= 1'b1;
    if (!rst_p && ((ar_p && !arr_p && !bus.arvalid) || (aw_p && !awr_p && !bus.awvalid) ||
                   (wv_p && !wr_p && !bus.wvalid)))
      stab_err <= 1'b1;
    if (bus.arvalid && !ar_p) ar_rise_cyc <= cyc - 1;
    if (bus.arvalid && bus.arready) begin n_ar <= n_ar + 1; last_araddr <= bus.araddr; end
    if (bus.rvalid && bus.rready) r_cyc <= cyc;
    if (bus.awvalid && bus.awready) begin n_aw <= n_aw + 1; last_awaddr <= bus.awaddr; end
    if (bus.wvalid && bus.wready) begin n_w <= n_w + 1; last_wdata <= bus.wdata; end
    if (bus.bvalid && bus.bready) begin n_b <= n_b + 1; b_cyc <= cyc; end
    ar_p <= bus.arvalid; arr_p <= bus.arready; aw_p <= bus.awvalid; awr_p <= bus.awready;
    wv_p <= bus.wvalid; wr_p <= bus.wready; rst_p <= rst;
  end

  int n_assert = 0, n_fail = 0;
  logic [7:0] spur_m;
  logic err_m;
  logic [31:0] cid;
  logic [1:0] rr, br;
  int unsigned w0, aw0, nb0, n;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int unsigned k = 0;
    while (!irq_valid_o && k < 40) begin tick(); k++; end
    chk(tag, irq_valid_o, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int unsigned k = 0;
    while (busy_o && k < 100) begin tick(); k++; end
    chk(tag, busy_o, 1'b0);
    repeat (HOLDOFF + 1) tick();
  endtask

  task automatic serve();
    repeat ($urandom_range(0, 2)) tick();
    irq_ready = 1'b1; tick(); irq_ready = 1'b0;
    repeat ($urandom_range(0, 3)) tick();
    chk("no_early_write", bus.awvalid, 1'b0);
    irq_done = 1'b1; tick(); irq_done = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_arvalid"}, bus.arvalid, 1'b0);
    chk({tag, "_rready"}, bus.rready, 1'b0);
    chk({tag, "_awvalid"}, bus.awvalid, 1'b0);
    chk({tag, "_wvalid"}, bus.wvalid, 1'b0);
    chk({tag, "_bready"}, bus.bready, 1'b0);
    chk({tag, "_irq_valid"}, irq_valid_o, 1'b0);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_bus_err"}, bus_err_o, 1'b0);
    chk({tag, "_spur"}, spur_cnt_o, 8'h00);
    chk({tag, "_irq_id"}, irq_id_o, '0);
  endtask

  // One complete claim sequence against the reference model: what should happen follows
  // directly from the claim response, the returned ID and the write response.
  task automatic do_irq(input logic [31:0] c, input logic [1:0] rresp, input logic [1:0] bresp);
    logic [ID_W-1:0] id;
    logic deliver;
    int unsigned a0, x0;
    id = c[ID_W-1:0];
    deliver = (rresp == 2'b00) && (id != '0);
    if (rresp != 2'b00) err_m = 1'b1;
    else if (id == '0 && spur_m != 8'hFF) spur_m = spur_m + 8'd1;
    if (deliver && bresp != 2'b00) err_m = 1'b1;
    claim_data = c; claim_resp = rresp; wr_resp = bresp;
    a0 = n_aw; x0 = n_w;
    ext_irq = 1'b1; tick(); ext_irq = 1'b0;
    en_i = 1'($urandom_range(0, 1));
    chk("claim_started", busy_o, 1'b1);
    n = 0;
    while (!irq_valid_o && busy_o && n < 40) begin tick(); n++; end
    chk("deliver", irq_valid_o, deliver);
    if (deliver) begin
      chk("irq_id", irq_id_o, id);
      serve();
    end
    wait_idle("seq_done");
    en_i = 1'b1;
    chk("aw_count", n_aw - a0, deliver);
    chk("w_count", n_w - x0, deliver);
    if (deliver) chk("wdata", last_wdata, 32'(id));
    chk("spur_cnt", spur_cnt_o, spur_m);
    chk("bus_err", bus_err_o, err_m);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en_i = 1'b1; ext_irq = 1'b0; irq_ready = 1'b0; irq_done = 1'b0;
    spur_m = '0; err_m = 1'b0;
    repeat (3) tick();
    check_reset_state("reset");
    rst = 1'b0;
    tick();
    check_reset_state("post_reset");

    // Disabled sequencer ignores a pending irq.
    en_i = 1'b0; ext_irq = 1'b1;
    repeat (5) tick();
    chk("disabled_arvalid", bus.arvalid, 1'b0);
    chk("disabled_busy", busy_o, 1'b0);
    ext_irq = 1'b0; en_i = 1'b1; tick();

    // Source 3 pending, zero-wait slave: latency, address, ID, done-with-ready ignored.
    claim_data = 32'd3; claim_resp = 2'b00; wr_resp = 2'b00;
    w0 = n_w;
    ext_irq = 1'b1; tick(); ext_irq = 1'b0;
    chk("t1_arvalid", bus.arvalid, 1'b1);
    chk("t1_araddr", bus.araddr, BASE + 32'h4);
    chk("t1_busy", busy_o, 1'b1);
    tick();
    chk("t1_valid_early", irq_valid_o, 1'b0);
    tick();
    chk("t1_latency_valid", irq_valid_o, 1'b1);
    chk("t1_irq_id", irq_id_o, 4'd3);
    irq_ready = 1'b1; irq_done = 1'b1; tick(); irq_ready = 1'b0; irq_done = 1'b0;
    chk("t1_valid_drop", irq_valid_o, 1'b0);
    repeat (3) tick();
    chk("t1_done_with_ready_ignored", bus.awvalid, 1'b0);
    irq_done = 1'b1; tick(); irq_done = 1'b0;
    chk("t1_awvalid", bus.awvalid, 1'b1);
    chk("t1_awaddr", bus.awaddr, BASE + 32'h4);
    chk("t1_wstrb", bus.wstrb, 4'hF);
    wait_idle("t1_done");
    chk("t1_writes", n_w - w0, 1);
    chk("t1_wdata", last_wdata, 32'd3);

    // Spurious claims: counter increments and saturates; upper rdata bits ignored.
    do_irq(32'h0, 2'b00, 2'b00);
    chk("spur_first", spur_cnt_o, 8'd1);
    for (int i = 0; i < 255; i++) begin
      cid = $urandom; cid[3:0] = 4'h0;
      do_irq(cid, 2'b00, 2'b00);
    end
    chk("spur_at_max", spur_cnt_o, 8'hFF);
    do_irq(32'hABC0, 2'b00, 2'b00);
    chk("spur_saturated", spur_cnt_o, 8'hFF);

    // Read error with irq still pending: no write, re-claim HOLDOFF+1 cycles later, serviced.
    w0 = n_w;
    claim_data = 32'd6; claim_resp = 2'b11;
    ext_irq = 1'b1;
    n = 0;
    while (!bus_err_o && n < 20) begin tick(); n++; end
    chk("t3_bus_err", bus_err_o, 1'b1);
    err_m = 1'b1;
    claim_resp = 2'b00;
    chk("t3_no_valid", irq_valid_o, 1'b0);
    n = 0;
    while (!bus.arvalid && n < 20) begin tick(); n++; end
    ext_irq = 1'b0;
    tick();
    chk("t3_reclaim_gap", ar_rise_cyc - r_cyc, HOLDOFF + 1);
    wait_valid("t3_next_valid");
    chk("t3_next_id", irq_id_o, 4'd6);
    serve();
    wait_idle("t3_done");
    chk("t3_one_write", n_w - w0, 1);
    chk("t3_wdata", last_wdata, 32'd6);

    // irq held high after complete: next claim HOLDOFF+1 cycles after the B handshake.
    w0 = n_w; nb0 = n_b;
    claim_data = 32'd9; ext_irq = 1'b1;
    wait_valid("t5_valid");
    chk("t5_id", irq_id_o, 4'd9);
    claim_data = 32'd0;
    serve();
    n = 0;
    while (n_b == nb0 && n < 30) begin tick(); n++; end
    chk("t5_b_seen", n_b - nb0, 1);
    n = 0;
    while (!bus.arvalid && n < 20) begin tick(); n++; end
    ext_irq = 1'b0;
    tick();
    chk("t5_reclaim_gap", ar_rise_cyc - b_cyc, HOLDOFF + 1);
    spur_m = (spur_m == 8'hFF) ? spur_m : spur_m + 8'd1;
    wait_idle("t5_done");
    chk("t5_one_write", n_w - w0, 1);
    chk("t5_spur", spur_cnt_o, spur_m);

    // Slow slave: valids must hold, AW and W never overlap, single write.
    ar_dly = 0; aw_dly = 5; w_dly = 3; b_dly = 4;
    do_irq(32'hA, 2'b00, 2'b00);
    chk("t4_no_overlap", ovl_err, 1'b0);
    chk("t4_stable", stab_err, 1'b0);

    // Randomized sequences.
    for (int i = 0; i < 30; i++) begin
      ar_dly = $urandom_range(0, 3); aw_dly = $urandom_range(0, 4);
      w_dly = $urandom_range(0, 4); b_dly = $urandom_range(0, 4);
      cid = $urandom;
      if ($urandom_range(0, 3) == 0) cid[3:0] = 4'h0;
      rr = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      br = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_irq(cid, rr, br);
    end
    chk("rand_no_overlap", ovl_err, 1'b0);
    chk("rand_stable", stab_err, 1'b0);
    chk("last_araddr", last_araddr, BASE + 32'h4);
    chk("last_awaddr", last_awaddr, BASE + 32'h4);

    // Reset while in SERVICE.
    ar_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
    claim_data = 32'd5; claim_resp = 2'b00; wr_resp = 2'b00;
    ext_irq = 1'b1; tick(); ext_irq = 1'b0;
    wait_valid("t6a_valid");
    irq_ready = 1'b1; tick(); irq_ready = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    spur_m = '0; err_m = 1'b0;
    check_reset_state("t6a");
    tick();
    do_irq(32'd5, 2'b00, 2'b00);

    // Reset while in W.
    w_dly = 5;
    w0 = n_w;
    claim_data = 32'd7;
    ext_irq = 1'b1; tick(); ext_irq = 1'b0;
    wait_valid("t6b_valid");
    serve();
    n = 0;
    while (!bus.wvalid && n < 20) begin tick(); n++; end
    chk("t6b_in_w", bus.wvalid, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    spur_m = '0; err_m = 1'b0;
    check_reset_state("t6b");
    chk("t6b_no_write", n_w - w0, 0);
    w_dly = 0;
    tick();
    do_irq(32'd7, 2'b00, 2'b00);
    chk("final_no_overlap", ovl_err, 1'b0);
    chk("final_stable", stab_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
